snake_body_tracker: RTL and testbench

Parametrised snake-body state engine for the snake game. It holds up to MAX_LEN grid segments and advances them one cell per `step` pulse. It applies direction changes with reversal rejection, grows on request, and detects wall and self collision. A registered per-pixel membership lookup lets the VGA renderer draw the body. It sits between the button/tick logic and the VGA colour mux, on the `clk_div` domain.

---
 rtl/snake_body_tracker.sv | 125 ++++++++++++
 tb/tb_snake_body_tracker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_tracker.sv
// snake_body_tracker: snake segment storage, movement, growth, collision and render lookup
module snake_body_tracker #(
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 20,
    parameter int INIT_Y   = 15,
    parameter int L_W      = $clog2(MAX_LEN + 1)
) (
    input  logic           clk_div,
    input  logic           rst,
    input  logic           step,
    input  logic [1:0]     dir_req,
    input  logic           grow,
    input  logic [X_W-1:0] pix_x,
    input  logic [Y_W-1:0] pix_y,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic [L_W-1:0] length,
    output logic           body_hit,
    output logic           head_hit,
    output logic           game_over,
    output logic           moved
);
    typedef enum logic {RUN, DEAD} state_t;
    localparam logic [1:0] RIGHT = 2'd0, LEFT = 2'd1, UP = 2'd2, DOWN = 2'd3;

    state_t         state_q, state_d;
    logic [X_W-1:0] seg_x_q [MAX_LEN];
    logic [Y_W-1:0] seg_y_q [MAX_LEN];
    logic [1:0]     dir_q, dir_d, dir_n;
    logic [L_W-1:0] len_q, len_d, lim;
    logic           grow_pend_q, grow_pend_d, moved_q, moved_d;
    logic           body_hit_q, body_hit_d, head_hit_q, head_hit_d;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           wall, self_hit, grow_eff, collide;

    // Wall is detected on the current head so the next-head arithmetic never has to wrap
    always_comb begin
        dir_n = (dir_req[1] == dir_q[1] && dir_req[0] != dir_q[0]) ? dir_q : dir_req;
        wall = dir_n == RIGHT ? seg_x_q[0] == X_W'(GRID_W - 1) :
               dir_n == LEFT  ? seg_x_q[0] == '0 :
               dir_n == UP    ? seg_y_q[0] == '0 : seg_y_q[0] == Y_W'(GRID_H - 1);
        nx = dir_n == RIGHT ? seg_x_q[0] + X_W'(1) : dir_n == LEFT ? seg_x_q[0] - X_W'(1) : seg_x_q[0];
        ny = dir_n == DOWN ? seg_y_q[0] + Y_W'(1) : dir_n == UP ? seg_y_q[0] - Y_W'(1) : seg_y_q[0];
        grow_eff = (grow_pend_q | grow) && len_q != L_W'(MAX_LEN);
        lim = grow_eff ? len_q : len_q - L_W'(1);
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            self_hit |= L_W'(i) < lim && seg_x_q[i] == nx && seg_y_q[i] == ny;
        collide = wall | self_hit;
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        len_d       = len_q;
        grow_pend_d = grow_pend_q;
        moved_d     = 1'b0;
        if (state_q == RUN) begin
            grow_pend_d = step ? 1'b0 : grow_pend_q | grow;
            if (step) begin
                state_d = collide ? DEAD : RUN;
                moved_d = ~collide;
                dir_d   = collide ? dir_q : dir_n;
                len_d   = !collide && grow_eff ? len_q + L_W'(1) : len_q;
            end
        end
    end

    always_comb begin
        head_hit_d = pix_x == seg_x_q[0] && pix_y == seg_y_q[0];
        body_hit_d = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            body_hit_d |= L_W'(i) < len_q && pix_x == seg_x_q[i] && pix_y == seg_y_q[i];
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            dir_q       <= RIGHT;
            len_q       <= L_W'(INIT_LEN);
            grow_pend_q <= 1'b0;
            moved_q     <= 1'b0;
            body_hit_q  <= 1'b0;
            head_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            grow_pend_q <= grow_pend_d;
            moved_q     <= moved_d;
            body_hit_q  <= body_hit_d;
            head_hit_q  <= head_hit_d;
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= i < INIT_LEN ? X_W'(INIT_X - i) : '0;
                seg_y_q[i] <= i < INIT_LEN ? Y_W'(INIT_Y) : '0;
            end
        end else if (moved_d) begin
            seg_x_q[0] <= nx;
            seg_y_q[0] <= ny;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
            end
        end
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = len_q;
    assign body_hit  = body_hit_q;
    assign head_hit  = head_hit_q;
    assign game_over = state_q == DEAD;
    assign moved     = moved_q;
endmodule

// File: tb/tb_snake_body_tracker.sv
// tb_snake_body_tracker: randomized and directed checks against a queue-based snake model
module tb_snake_body_tracker;
    logic       clk_div = 1'b0, rst = 1'b1, step = 1'b0, grow = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic [5:0] pix_x = '0;
    logic [4:0] pix_y = '0;
    logic [5:0] head_x, s_head_x;
    logic [4:0] head_y, s_head_y, length;
    logic [2:0] s_length;
    logic       body_hit, head_hit, game_over, moved;
    logic       s_body_hit, s_head_hit, s_game_over, s_moved;

    always #5 clk_div = ~clk_div;

    snake_body_tracker dut (
        .clk_div(clk_div), .rst(rst), .step(step), .dir_req(dir_req), .grow(grow),
        .pix_x(pix_x), .pix_y(pix_y), .head_x(head_x), .head_y(head_y), .length(length),
        .body_hit(body_hit), .head_hit(head_hit), .game_over(game_over), .moved(moved)
    );

    snake_body_tracker #(.MAX_LEN(4)) dut4 (
        .clk_div(clk_div), .rst(rst), .step(step), .dir_req(dir_req), .grow(grow),
        .pix_x(pix_x), .pix_y(pix_y), .head_x(s_head_x), .head_y(s_head_y), .length(s_length),
        .body_hit(s_body_hit), .head_hit(s_head_hit), .game_over(s_game_over), .moved(s_moved)
    );

    int bx[$], by[$];
    int m_dir;
    bit m_pend, m_dead, m_moved, e_bh, e_hh;
    int errors = 0, checks = 0;

    function automatic void model_reset();
        bx = '{20, 19, 18};
        by = '{15, 15, 15};
        m_dir = 0;
        {m_pend, m_dead, m_moved, e_bh, e_hh} = '0;
    endfunction

    // Snake as a coordinate list: new head pushed at the front, tail popped unless growing
    function automatic void model_step(input bit g, input int d);
        int nx, ny, keep;
        bit ge;
        m_moved = 0;
        if (m_dead) return;
        ge = (m_pend || g) && bx.size() < 16;
        m_pend = 0;
        if ((d ^ m_dir) != 1) m_dir = d;
        nx = bx[0] + (m_dir == 0 ? 1 : m_dir == 1 ? -1 : 0);
        ny = by[0] + (m_dir == 3 ? 1 : m_dir == 2 ? -1 : 0);
        if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30) begin m_dead = 1; return; end
        keep = ge ? bx.size() : bx.size() - 1;
        for (int i = 0; i < keep; i++)
            if (bx[i] == nx && by[i] == ny) begin m_dead = 1; return; end
        bx.push_front(nx);
        by.push_front(ny);
        if (!ge) begin void'(bx.pop_back()); void'(by.pop_back()); end
        m_moved = 1;
    endfunction

    function automatic logic [19:0] obs();
        return {head_x, head_y, length, moved, game_over, body_hit, head_hit};
    endfunction

    function automatic logic [19:0] expv();
        return {6'(bx[0]), 5'(by[0]), 5'(bx.size()), m_moved, m_dead, e_bh, e_hh};
    endfunction

    task automatic do_reset();
        rst = 1'b1; step = 1'b0; grow = 1'b0;
        @(posedge clk_div);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic cyc(input bit s, input bit g, input bit [1:0] d, input int px, input int py);
        step = s; grow = g; dir_req = d; pix_x = 6'(px); pix_y = 5'(py);
        @(posedge clk_div);
        e_hh = bx[0] == px && by[0] == py;
        e_bh = 0;
        for (int i = 1; i < bx.size(); i++) if (bx[i] == px && by[i] == py) e_bh = 1;
        m_moved = 0;
        if (s) model_step(g, d);
        else if (g && !m_dead) m_pend = 1;
        #1 step = 1'b0; grow = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (obs() !== expv()) begin errors++; $display("FAIL reset got=%h exp=%h", obs(), expv()); end
        checks++; if ({head_x, head_y, length} !== {6'd20, 5'd15, 5'd3}) begin errors++; $display("FAIL reset_head got=%h exp=%h", {head_x, head_y, length}, {6'd20, 5'd15, 5'd3}); end
        checks++; if (s_length !== 3'd3) begin errors++; $display("FAIL reset_len4 got=%0d exp=3", s_length); end
    endtask

    task automatic test_back_to_back();
        int qx[3] = '{19, 20, 18};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 2'd0, qx[k], 15);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL b2b_step%0d got=%h exp=%h", k, obs(), expv()); end
            checks++; if (head_x !== 6'(21 + k) || moved !== 1'b1) begin errors++; $display("FAIL b2b_head%0d got=%0d/%b exp=%0d/1", k, head_x, moved, 21 + k); end
        end
        cyc(0, 0, 2'd0, 22, 15);
        checks++; if (obs() !== expv()) begin errors++; $display("FAIL b2b_idle got=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_reversal();
        do_reset();
        cyc(1, 0, 2'd1, 0, 0);
        checks++; if ({head_x, head_y} !== {6'd21, 5'd15} || obs() !== expv()) begin errors++; $display("FAIL reversal got=%h exp=%h", obs(), expv()); end
        cyc(1, 0, 2'd2, 0, 0);
        checks++; if ({head_x, head_y} !== {6'd21, 5'd14} || obs() !== expv()) begin errors++; $display("FAIL turn_up got=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_grow();
        do_reset();
        cyc(0, 1, 2'd0, 0, 0);
        checks++; if (length !== 5'd3 || obs() !== expv()) begin errors++; $display("FAIL grow_idle got=%h exp=%h", obs(), expv()); end
        cyc(1, 0, 2'd0, 0, 0);
        checks++; if (length !== 5'd4 || obs() !== expv()) begin errors++; $display("FAIL grow_step1 got=%h exp=%h", obs(), expv()); end
        cyc(1, 0, 2'd0, 0, 0);
        checks++; if (length !== 5'd4 || obs() !== expv()) begin errors++; $display("FAIL grow_step2 got=%h exp=%h", obs(), expv()); end
        cyc(1, 1, 2'd0, 0, 0);
        checks++; if (length !== 5'd5 || obs() !== expv()) begin errors++; $display("FAIL grow_same got=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_wall();
        do_reset();
        for (int k = 0; k < 19; k++) begin
            cyc(1, 0, 2'd0, 20, 15);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL wall_run%0d got=%h exp=%h", k, obs(), expv()); end
        end
        cyc(1, 0, 2'd0, 39, 15);
        checks++; if (game_over !== 1'b1 || head_x !== 6'd39 || moved !== 1'b0) begin errors++; $display("FAIL wall_hit got=%b/%0d/%b exp=1/39/0", game_over, head_x, moved); end
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 38, 15);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL wall_dead%0d got=%h exp=%h", k, obs(), expv()); end
        end
    endtask

    task automatic test_self();
        bit [1:0] ds[5] = '{2'd0, 2'd0, 2'd3, 2'd1, 2'd2};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1, k < 2, ds[k], 21, 15);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL self%0d got=%h exp=%h", k, obs(), expv()); end
        end
        checks++; if (game_over !== 1'b1 || length !== 5'd5) begin errors++; $display("FAIL self_dead got=%b/%0d exp=1/5", game_over, length); end
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1, k == 0, ds[k + 1], 20, 16);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL tail%0d got=%h exp=%h", k, obs(), expv()); end
        end
        checks++; if (game_over !== 1'b0 || moved !== 1'b1 || {head_x, head_y} !== {6'd20, 5'd15}) begin errors++; $display("FAIL tail_vacate got=%b/%b/%0d,%0d exp=0/1/20,15", game_over, moved, head_x, head_y); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 2'd0, 0, 0);
            checks++; if (s_length !== 3'd4) begin errors++; $display("FAIL sat%0d got=%0d exp=4", k, s_length); end
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL sat_main%0d got=%h exp=%h", k, obs(), expv()); end
        end
    endtask

    task automatic test_random();
        int px, py, j;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if (m_dead) do_reset();
            if ($urandom_range(0, 1) == 1) begin
                j = $urandom_range(0, bx.size() - 1);
                px = bx[j]; py = by[j];
            end else begin
                px = $urandom_range(0, 39); py = $urandom_range(0, 29);
            end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), px, py);
            checks++; if (obs() !== expv()) begin errors++; $display("FAIL rand%0d got=%h exp=%h", k, obs(), expv()); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1, 1, 2'd3, 20, 15);
        cyc(1, 0, 2'd3, 20, 16);
        #2 rst = 1'b1;
        #1;
        checks++; if (obs() !== {6'd20, 5'd15, 5'd3, 4'b0000}) begin errors++; $display("FAIL async_rst got=%h exp=%h", obs(), {6'd20, 5'd15, 5'd3, 4'b0000}); end
        checks++; if ({s_head_x, s_head_y, s_length, s_moved, s_game_over, s_body_hit, s_head_hit} !== {6'd20, 5'd15, 3'd3, 4'b0000}) begin errors++; $display("FAIL async_rst4 got=%h", {s_head_x, s_head_y, s_length, s_moved, s_game_over, s_body_hit, s_head_hit}); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_reversal();
        test_grow();
        test_wall();
        test_self();
        test_saturate();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
